// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg: register map, response codes, FSM states and byte-strobe merge for axi_lite_regbank.
package axi_lite_regbank_pkg;
  localparam int CTRL = 0;
  localparam int STAT = 1;
  localparam int CFG_BASE = 2;
  localparam int CTRL_START = 0;
  localparam int CTRL_IEN = 1;
  localparam int STAT_READY = 0;
  localparam int STAT_DONE = 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave with CTRL/STAT/CFG registers driving a start/ready/done core handshake.
// Define AXI_LITE_REGBANK_IRQ_EN to enable the CTRL.IEN bit and the registered irq_o = DONE & IEN.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0] s00_axi_awprot,
  input  logic s00_axi_awvalid,
  output logic s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic s00_axi_wvalid,
  output logic s00_axi_wready,
  output logic [1:0] s00_axi_bresp,
  output logic s00_axi_bvalid,
  input  logic s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0] s00_axi_arprot,
  input  logic s00_axi_arvalid,
  output logic s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0] s00_axi_rresp,
  output logic s00_axi_rvalid,
  input  logic s00_axi_rready,
  output logic start_o,
  input  logic ready_i,
  input  logic done_i,
  output logic [(NUM_REGS-2)*C_S00_AXI_DATA_WIDTH-1:0] cfg_o,
  output logic irq_o
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic live, aw_got, w_got, ien, done;
  logic aw_hs, w_hs, ar_hs, wr_commit, wr_ok, rd_ok, wr_ctrl, wr_stat;
  logic [AW-3:0] aw_idx, wr_idx;
  logic [DW-1:0] w_data, wr_data, rd_val;
  logic [DW/8-1:0] w_strb, wr_strb;
  logic [DW-1:0] cfg [CFG_BASE:NUM_REGS-1];
  int wr_n, rd_n;
  logic unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  // A beat captured in an earlier cycle wins over the live bus value.
  assign wr_idx = aw_got ? aw_idx : s00_axi_awaddr[AW-1:2];
  assign wr_data = w_got ? w_data : s00_axi_wdata;
  assign wr_strb = w_got ? w_strb : s00_axi_wstrb;
  assign wr_commit = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_n = int'(wr_idx);
  assign rd_n = int'(s00_axi_araddr[AW-1:2]);
  assign wr_ok = wr_n < NUM_REGS;
  assign rd_ok = rd_n < NUM_REGS;
  assign wr_ctrl = wr_commit && wr_n == CTRL && wr_strb[0];
  assign wr_stat = wr_commit && wr_n == STAT && wr_strb[0];
  always_comb begin
    rd_val = rd_n == CTRL ? DW'({ien, 1'b0}) : rd_n == STAT ? DW'({done, ready_i}) : '0;
    for (int i = CFG_BASE; i < NUM_REGS; i++) if (rd_n == i) rd_val = cfg[i];
  end
  always_ff @(posedge clk) begin
    wr_state <= rst ? WR_IDLE : wr_next;
    rd_state <= rst ? RD_IDLE : rd_next;
  end
  always_comb begin
    wr_next = wr_state == WR_IDLE ? (wr_commit ? WR_RESP : WR_IDLE) : (s00_axi_bready ? WR_IDLE : WR_RESP);
    rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_DATA : RD_IDLE) : (s00_axi_rready ? RD_IDLE : RD_DATA);
  end
  // live keeps the ready signals low while reset is held.
  always_comb begin
    s00_axi_awready = live && wr_state == WR_IDLE && !aw_got;
    s00_axi_wready = live && wr_state == WR_IDLE && !w_got;
    s00_axi_bvalid = wr_state == WR_RESP;
    s00_axi_arready = live && rd_state == RD_IDLE;
    s00_axi_rvalid = rd_state == RD_DATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      s00_axi_bresp <= RESP_OKAY;
      s00_axi_rresp <= RESP_OKAY;
      s00_axi_rdata <= '0;
      start_o <= 1'b0;
      done <= 1'b0;
      ien <= 1'b0;
      irq_o <= 1'b0;
      for (int i = CFG_BASE; i < NUM_REGS; i++) cfg[i] <= '0;
    end else begin
      live <= 1'b1;
      aw_got <= !wr_commit && (aw_got || aw_hs);
      w_got <= !wr_commit && (w_got || w_hs);
      if (aw_hs) aw_idx <= s00_axi_awaddr[AW-1:2];
      if (w_hs) begin
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (wr_commit) s00_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        s00_axi_rdata <= rd_val;
        s00_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      start_o <= wr_ctrl && wr_data[CTRL_START];
      done <= done_i || (done && !(wr_stat && wr_data[STAT_DONE]));
`ifdef AXI_LITE_REGBANK_IRQ_EN
      if (wr_ctrl) ien <= wr_data[CTRL_IEN];
      irq_o <= done && ien;
`else
      ien <= 1'b0;
      irq_o <= 1'b0;
`endif
      for (int i = CFG_BASE; i < NUM_REGS; i++)
        if (wr_commit && wr_n == i) cfg[i] <= strb_merge(cfg[i], wr_data, wr_strb);
    end
  end
  for (genvar i = CFG_BASE; i < NUM_REGS; i++) begin : g_cfg
    assign cfg_o[(i-CFG_BASE)*DW +: DW] = cfg[i];
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: randomized AXI-Lite traffic against a register-map reference model, plus directed corner cases.
module tb_axi_lite_regbank;
  import axi_lite_regbank_pkg::*;
  localparam int NR = 7;
`ifdef AXI_LITE_REGBANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic start_o, ready_i = 0, done_i = 0, irq_o;
  logic [(NR-2)*32-1:0] cfg_o;
  int checks, errors;
  always #5 clk = ~clk;
  axi_lite_regbank #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(5), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .start_o(start_o), .ready_i(ready_i), .done_i(done_i), .cfg_o(cfg_o), .irq_o(irq_o)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic m_ien, m_done;
  logic [31:0] m_cfg [CFG_BASE:NR-1];
  function automatic logic [31:0] m_read(input int idx);
    if (idx == CTRL) return {30'b0, m_ien, 1'b0};
    if (idx == STAT) return {30'b0, m_done, ready_i};
    if (idx < NR) return m_cfg[idx];
    return 32'h0;
  endfunction
  function automatic void m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx == CTRL && s[0]) m_ien = IRQ_EN && d[1];
    if (idx == STAT && s[0] && d[1]) m_done = 1'b0;
    if (idx >= CFG_BASE && idx < NR)
      for (int b = 0; b < 4; b++) if (s[b]) m_cfg[idx][8*b +: 8] = d[8*b +: 8];
  endfunction
  function automatic void m_reset();
    m_ien = 1'b0;
    m_done = 1'b0;
    for (int i = CFG_BASE; i < NR; i++) m_cfg[i] = '0;
  endfunction
  function automatic logic [(NR-2)*32-1:0] m_cfg_o();
    logic [(NR-2)*32-1:0] r;
    for (int i = CFG_BASE; i < NR; i++) r[(i-CFG_BASE)*32 +: 32] = m_cfg[i];
    return r;
  endfunction
  int start_cnt, start_long;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (start_o === 1'b1) start_cnt++;
    if (start_o === 1'b1 && start_prev) start_long++;
    start_prev = (start_o === 1'b1);
  end
  // order: 0 = AW before W, 1 = W before AW, 2 = same cycle; all tasks start and end just after a negedge
  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int order, input int bdly, output logic [1:0] resp);
    int t = 0;
    bit ad = 0, wd = 0, a, w;
    awaddr = {idx[2:0], 2'($urandom)};
    wdata = d;
    wstrb = s;
    awvalid = (order != 1);
    wvalid = (order != 0);
    while (!(ad && wd) && t < 20) begin
      a = awvalid && awready;
      w = wvalid && wready;
      @(negedge clk);
      t++;
      if (a) begin ad = 1; awvalid = 0; end
      if (w) begin wd = 1; wvalid = 0; end
      if (ad && !wd) begin chk("awready_low_after_aw", awready, 0); wvalid = 1; end
      if (wd && !ad) begin chk("wready_low_after_w", wready, 0); awvalid = 1; end
    end
    awvalid = 0;
    wvalid = 0;
    chk("write_handshake", {ad, wd}, 2'b11);
    chk("bvalid_after_commit", bvalid, 1);
    resp = bresp;
    repeat (bdly) begin
      @(negedge clk);
      chk("bvalid_held", {bvalid, bresp}, {1'b1, resp});
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_drop_ready_back", {bvalid, awready, wready}, 3'b011);
  endtask
  task automatic axi_read(input int idx, input int rdly, output logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    bit h = 0;
    araddr = {idx[2:0], 2'($urandom)};
    arvalid = 1;
    while (!h && t < 20) begin
      h = arready;
      @(negedge clk);
      t++;
    end
    arvalid = 0;
    chk("ar_handshake", h, 1);
    chk("rvalid_after_ar", rvalid, 1);
    d = rdata;
    resp = rresp;
    repeat (rdly) begin
      @(negedge clk);
      chk("rdata_held", {rvalid, rresp, rdata}, {1'b1, resp, d});
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rvalid_drop", {rvalid, arready}, 2'b01);
  endtask
  task automatic pulse_done();
    done_i = 1;
    @(negedge clk);
    done_i = 0;
    m_done = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d, old;
    logic [1:0] r, r2;
    int sc, op, idx;
    logic [31:0] wd;
    logic [3:0] ws;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid}, 0);
    chk("rst_core", {start_o, irq_o}, 0);
    chk("rst_resp_rdata", {bresp, rresp, rdata}, 0);
    chk("rst_cfg", cfg_o, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);
    axi_write(2, 32'hDEADBEEF, 4'hF, 0, 1, r);
    m_write(2, 32'hDEADBEEF, 4'hF);
    chk("w08_bresp", r, RESP_OKAY);
    chk("w08_cfg", cfg_o[31:0], 32'hDEADBEEF);
    axi_read(2, 0, d, r);
    chk("r08", {r, d}, {RESP_OKAY, 32'hDEADBEEF});
    axi_write(3, 32'h11223344, 4'hF, 2, 0, r);
    m_write(3, 32'h11223344, 4'hF);
    axi_write(3, 32'h0000AA55, 4'h1, 1, 2, r);
    m_write(3, 32'h0000AA55, 4'h1);
    axi_read(3, 1, d, r);
    chk("r0c_partial", d, 32'h11223355);
    sc = start_cnt;
    axi_write(0, 32'h1, 4'h1, 2, 0, r);
    m_write(0, 32'h1, 4'h1);
    chk("start_pulses", start_cnt - sc, 1);
    axi_read(0, 0, d, r);
    chk("ctrl_read", d, 32'h0);
    axi_write(0, 32'h2, 4'h1, 0, 0, r);
    m_write(0, 32'h2, 4'h1);
    pulse_done();
    chk("irq_set", irq_o, IRQ_EN);
    axi_read(1, 0, d, r);
    chk("stat_done", d[1], 1);
    axi_write(1, 32'h2, 4'h1, 2, 0, r);
    m_write(1, 32'h2, 4'h1);
    chk("irq_clr", irq_o, 0);
    axi_read(1, 0, d, r);
    chk("stat_clr", d, m_read(1));
    fork
      axi_write(1, 32'h2, 4'h1, 2, 0, r);
      begin done_i = 1; @(negedge clk); done_i = 0; end
    join
    m_write(1, 32'h2, 4'h1);
    m_done = 1'b1;
    axi_read(1, 0, d, r);
    chk("w1c_vs_done", d[1], 1);
    old = m_read(4);
    fork
      axi_write(4, 32'hCAFEF00D, 4'hF, 2, 0, r);
      axi_read(4, 0, d, r2);
    join
    m_write(4, 32'hCAFEF00D, 4'hF);
    chk("read_pre_write", d, old);
    chk("cfg_after_concurrent", cfg_o, m_cfg_o());
    axi_read(7, 0, d, r);
    chk("rd_slverr", {r, d}, {RESP_SLVERR, 32'h0});
    axi_write(7, $urandom, 4'hF, 0, 0, r);
    chk("wr_slverr", r, RESP_SLVERR);
    chk("wr_slverr_cfg", cfg_o, m_cfg_o());
    repeat (150) begin
      op = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      wd = $urandom;
      ws = 4'($urandom);
      ready_i = 1'($urandom);
      if (op < 4) begin
        sc = start_cnt;
        axi_write(idx, wd, ws, $urandom_range(0, 2), $urandom_range(0, 3), r);
        chk("rnd_bresp", r, idx < NR ? RESP_OKAY : RESP_SLVERR);
        chk("rnd_start", start_cnt - sc, (idx == CTRL && ws[0] && wd[0]) ? 1 : 0);
        m_write(idx, wd, ws);
        chk("rnd_cfg_o", cfg_o, m_cfg_o());
      end else if (op < 8) begin
        axi_read(idx, $urandom_range(0, 3), d, r);
        chk("rnd_rdata", {r, d}, {(idx < NR) ? RESP_OKAY : RESP_SLVERR, m_read(idx)});
      end else pulse_done();
      chk("rnd_irq", irq_o, IRQ_EN && m_done && m_ien);
    end
    awaddr = 5'h08;
    wdata = $urandom;
    wstrb = 4'hF;
    awvalid = 1;
    wvalid = 1;
    @(negedge clk);
    awvalid = 0;
    wvalid = 0;
    repeat (5) begin
      chk("bvalid_wait", bvalid, 1);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    m_reset();
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_cfg_o", cfg_o, 0);
    chk("mid_rst_awready", awready, 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_resp_after_rst", bvalid, 0);
    end
    chk("awready_back", awready, 1);
    for (int i = 0; i < NR; i++) begin
      axi_read(i, 0, d, r);
      chk("post_rst_read", {r, d}, {RESP_OKAY, m_read(i)});
    end
    chk("start_single_cycle", start_long, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
